// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data-memory arbiter slice.
package dmem_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DEPTH_DEF  = 128;

  localparam logic REQ_CORE = 1'b0;
  localparam logic REQ_DBG  = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Combinational two-way round-robin pick; ties go to the requester that did not win last.
module rr_arb2
  import dmem_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic       o_winner,
  output logic       o_valid
);

  always_comb begin
    o_valid  = |i_req;
    o_winner = REQ_CORE;
    if (&i_req) begin
      o_winner = ~i_last;
    end else if (i_req[1]) begin
      o_winner = REQ_DBG;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Core/debug arbiter and sequencer for the single-port data memory.
// Optional address bounds check and sticky err port: DMEM_BOUNDS_CHECK_EN.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_ack,
  output logic [DATA_W-1:0] c_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
`ifdef DMEM_BOUNDS_CHECK_EN
  ,
  output logic              err
`endif
);

`ifdef DMEM_BOUNDS_CHECK_EN
  localparam bit BOUNDS_EN = 1'b1;
`else
  localparam bit BOUNDS_EN = 1'b0;
`endif

  state_t            r_state;
  state_t            w_next;
  logic              r_last;
  logic              r_id;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_c_rdata;
  logic [DATA_W-1:0] r_d_rdata;
  logic              w_win;
  logic              w_valid;
  logic              w_latch;
  logic              w_oob;

  rr_arb2 u_arb (
    .i_req    ({d_req, c_req}),
    .i_last   (r_last),
    .o_winner (w_win),
    .o_valid  (w_valid)
  );

  // The request register doubles as the memory address/data drivers, so they
  // naturally hold their last value outside BUSY.
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign c_rdata   = r_c_rdata;
  assign d_rdata   = r_d_rdata;
  assign busy      = (r_state != IDLE);
  assign w_oob     = BOUNDS_EN && (r_addr >= ADDR_W'(DEPTH));

  always_comb begin
    w_next  = r_state;
    w_latch = 1'b0;
    c_gnt   = 1'b0;
    d_gnt   = 1'b0;
    c_ack   = 1'b0;
    d_ack   = 1'b0;
    mem_we  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_valid) begin
          w_latch = 1'b1;
          w_next  = BUSY;
        end
      end
      BUSY: begin
        c_gnt  = (r_id == REQ_CORE);
        d_gnt  = (r_id == REQ_DBG);
        mem_we = r_we && !w_oob;
        w_next = RESP;
      end
      RESP: begin
        c_ack = (r_id == REQ_CORE);
        d_ack = (r_id == REQ_DBG);
        if (w_valid) begin
          w_latch = 1'b1;
          w_next  = BUSY;
        end else begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
    // Reset aborts an in-flight access within the same cycle.
    if (rst) begin
      c_gnt  = 1'b0;
      d_gnt  = 1'b0;
      c_ack  = 1'b0;
      d_ack  = 1'b0;
      mem_we = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_last    <= REQ_DBG;
      r_id      <= REQ_CORE;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_c_rdata <= '0;
      r_d_rdata <= '0;
    end else begin
      r_state <= w_next;
      if (w_latch) begin
        r_id    <= w_win;
        r_we    <= w_win ? d_we    : c_we;
        r_addr  <= w_win ? d_addr  : c_addr;
        r_wdata <= w_win ? d_wdata : c_wdata;
      end
      if (r_state == BUSY) begin
        r_last <= r_id;
        if (!r_we) begin
          if (r_id == REQ_DBG) r_d_rdata <= w_oob ? '0 : mem_rdata;
          else                 r_c_rdata <= w_oob ? '0 : mem_rdata;
        end
      end
    end
  end

`ifdef DMEM_BOUNDS_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (r_state == BUSY && w_oob) begin
      err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a behavioural 128-word memory.
// Bounds-check scenario is built when DMEM_BOUNDS_CHECK_EN is defined.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        c_req = 1'b0, c_we = 1'b0;
  logic [31:0] c_addr = '0, c_wdata = '0;
  logic        c_gnt, c_ack;
  logic [31:0] c_rdata;
  logic        d_req = 1'b0, d_we = 1'b0;
  logic [31:0] d_addr = '0, d_wdata = '0;
  logic        d_gnt, d_ack;
  logic [31:0] d_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        busy;
`ifdef DMEM_BOUNDS_CHECK_EN
  logic        err;
`endif

  logic [31:0] mem [0:127];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Memory model: combinational read, write on the rising edge.
  always @(posedge clk) if (mem_we) mem[mem_addr[6:0]] = mem_wdata;
  assign mem_rdata = mem[mem_addr[6:0]];

  dmem_arbiter #(.DATA_W(32), .ADDR_W(32), .DEPTH(128)) dut (
    .clk       (clk),
    .rst       (rst),
    .c_req     (c_req),
    .c_we      (c_we),
    .c_addr    (c_addr),
    .c_wdata   (c_wdata),
    .c_gnt     (c_gnt),
    .c_ack     (c_ack),
    .c_rdata   (c_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_gnt     (d_gnt),
    .d_ack     (d_ack),
    .d_rdata   (d_rdata),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy)
`ifdef DMEM_BOUNDS_CHECK_EN
    ,
    .err       (err)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    c_req = 1'b0; d_req = 1'b0; c_we = 1'b0; d_we = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] ctl;
    do_reset();
    ctl = {c_gnt, c_ack, d_gnt, d_ack, mem_we, busy, 2'b00};
    total++; if (ctl !== 8'h00) begin bad++; $display("FAIL reset_ctl got=%h exp=00", ctl); end
    total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
    total++; if (mem_wdata !== 32'h0) begin bad++; $display("FAIL reset_mem_wdata got=%h exp=0", mem_wdata); end
    total++; if ({c_rdata, d_rdata} !== 64'h0) begin bad++; $display("FAIL reset_rdata got=%h/%h exp=0/0", c_rdata, d_rdata); end
  endtask

  task automatic test_core_read();
    do_reset();
    c_req = 1'b1; c_we = 1'b0; c_addr = 32'd5;
    step();
    total++; if ({c_gnt, d_gnt, mem_we, busy} !== 4'b1001) begin bad++; $display("FAIL cr_gnt got=%b exp=1001", {c_gnt, d_gnt, mem_we, busy}); end
    total++; if (mem_addr !== 32'd5) begin bad++; $display("FAIL cr_addr got=%0d exp=5", mem_addr); end
    c_req = 1'b0;
    step();
    total++; if ({c_ack, d_ack, c_gnt} !== 3'b100) begin bad++; $display("FAIL cr_ack got=%b exp=100", {c_ack, d_ack, c_gnt}); end
    total++; if (c_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL cr_rdata got=%h exp=deadbeef", c_rdata); end
    total++; if (d_rdata !== 32'h0) begin bad++; $display("FAIL cr_d_rdata got=%h exp=0", d_rdata); end
    step();
    total++; if ({busy, c_ack, c_gnt} !== 3'b000) begin bad++; $display("FAIL cr_idle got=%b exp=000", {busy, c_ack, c_gnt}); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    c_req = 1'b1; c_we = 1'b0; c_addr = 32'd3;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'd7; d_wdata = 32'h12345678;
    step();
    total++; if ({c_gnt, d_gnt, mem_we} !== 3'b100) begin bad++; $display("FAIL sim_core_gnt got=%b exp=100", {c_gnt, d_gnt, mem_we}); end
    total++; if (mem_addr !== 32'd3) begin bad++; $display("FAIL sim_core_addr got=%0d exp=3", mem_addr); end
    c_req = 1'b0;
    step();
    total++; if ({c_ack, d_ack, d_gnt} !== 3'b100) begin bad++; $display("FAIL sim_core_ack got=%b exp=100", {c_ack, d_ack, d_gnt}); end
    total++; if (c_rdata !== 32'h0BADF00D) begin bad++; $display("FAIL sim_core_rdata got=%h exp=0badf00d", c_rdata); end
    step();
    total++; if ({c_gnt, d_gnt, mem_we} !== 3'b011) begin bad++; $display("FAIL sim_dbg_gnt got=%b exp=011", {c_gnt, d_gnt, mem_we}); end
    total++; if ({mem_addr, mem_wdata} !== {32'd7, 32'h12345678}) begin bad++; $display("FAIL sim_dbg_bus got=%h/%h exp=7/12345678", mem_addr, mem_wdata); end
    d_req = 1'b0;
    step();
    total++; if ({c_ack, d_ack, mem_we} !== 3'b010) begin bad++; $display("FAIL sim_dbg_ack got=%b exp=010", {c_ack, d_ack, mem_we}); end
    total++; if (mem[7] !== 32'h12345678) begin bad++; $display("FAIL sim_mem7 got=%h exp=12345678", mem[7]); end
    total++; if (d_rdata !== 32'h0) begin bad++; $display("FAIL sim_d_rdata got=%h exp=0", d_rdata); end
  endtask

  task automatic test_fairness();
    int ngnt = 0;
    logic [3:0] exp;
    do_reset();
    c_req = 1'b1; c_we = 1'b0; c_addr = 32'd1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'd2;
    for (int k = 0; k < 16; k++) begin
      step();
      exp = {((k % 4) == 0), ((k % 4) == 2), ((k % 4) == 1), ((k % 4) == 3)};
      total++; if ({c_gnt, d_gnt, c_ack, d_ack} !== exp) begin bad++; $display("FAIL fair_k%0d got=%b exp=%b", k, {c_gnt, d_gnt, c_ack, d_ack}, exp); end
      if (c_gnt || d_gnt) ngnt++;
    end
    total++; if (ngnt !== 8) begin bad++; $display("FAIL fair_count got=%0d exp=8", ngnt); end
    total++; if ({c_rdata, d_rdata} !== {32'h00000101, 32'h00000202}) begin bad++; $display("FAIL fair_rdata got=%h/%h exp=101/202", c_rdata, d_rdata); end
    do_reset();
  endtask

  task automatic test_write_then_read();
    do_reset();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'd10; d_wdata = 32'hA5A5A5A5;
    step();
    total++; if ({d_gnt, mem_we} !== 2'b11) begin bad++; $display("FAIL wr_gnt got=%b exp=11", {d_gnt, mem_we}); end
    d_req = 1'b0;
    step();
    total++; if (d_ack !== 1'b1) begin bad++; $display("FAIL wr_ack got=%b exp=1", d_ack); end
    c_req = 1'b1; c_we = 1'b0; c_addr = 32'd10;
    step();
    total++; if ({c_gnt, mem_we, mem_addr} !== {2'b10, 32'd10}) begin bad++; $display("FAIL rd_gnt got=%b/%0d exp=10/10", {c_gnt, mem_we}, mem_addr); end
    c_req = 1'b0;
    step();
    total++; if ({c_ack, c_rdata} !== {1'b1, 32'hA5A5A5A5}) begin bad++; $display("FAIL rd_data got=%b/%h exp=1/a5a5a5a5", c_ack, c_rdata); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'd20; d_wdata = 32'hCAFEF00D;
    step();
    rst = 1'b1;
    #1;
    total++; if ({mem_we, d_gnt} !== 2'b00) begin bad++; $display("FAIL rmid_we got=%b exp=00", {mem_we, d_gnt}); end
    step();
    d_req = 1'b0; rst = 1'b0;
    total++; if (mem[20] !== 32'h11111111) begin bad++; $display("FAIL rmid_mem got=%h exp=11111111", mem[20]); end
    total++; if ({busy, d_gnt, d_ack, mem_we, mem_addr, mem_wdata} !== 68'h0) begin bad++; $display("FAIL rmid_out got=%b%b%b%b/%h/%h exp=0", busy, d_gnt, d_ack, mem_we, mem_addr, mem_wdata); end
    step();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_idle got=%b exp=0", busy); end
  endtask

  task automatic test_out_of_range();
    do_reset();
    c_req = 1'b1; c_we = 1'b1; c_addr = 32'd200; c_wdata = 32'h00000077;
    step();
    total++; if (mem_addr !== 32'd200) begin bad++; $display("FAIL oob_addr got=%0d exp=200", mem_addr); end
`ifdef DMEM_BOUNDS_CHECK_EN
    total++; if ({c_gnt, mem_we} !== 2'b10) begin bad++; $display("FAIL oob_gnt got=%b exp=10", {c_gnt, mem_we}); end
`else
    total++; if ({c_gnt, mem_we} !== 2'b11) begin bad++; $display("FAIL oob_gnt got=%b exp=11", {c_gnt, mem_we}); end
`endif
    c_req = 1'b0;
    step();
    total++; if (c_ack !== 1'b1) begin bad++; $display("FAIL oob_ack got=%b exp=1", c_ack); end
`ifdef DMEM_BOUNDS_CHECK_EN
    total++; if (mem[72] !== 32'h00000048) begin bad++; $display("FAIL oob_mem got=%h exp=48", mem[72]); end
    step(); step(); step();
    total++; if (err !== 1'b1) begin bad++; $display("FAIL oob_err got=%b exp=1", err); end
    do_reset();
    total++; if (err !== 1'b0) begin bad++; $display("FAIL oob_err_clr got=%b exp=0", err); end
`else
    total++; if (mem[72] !== 32'h00000077) begin bad++; $display("FAIL oob_mem got=%h exp=77", mem[72]); end
`endif
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 32'(i) | (32'(i) << 8);
    mem[3]  = 32'h0BADF00D;
    mem[5]  = 32'hDEADBEEF;
    mem[20] = 32'h11111111;
    mem[72] = 32'h00000048;
    test_reset();
    test_core_read();
    test_simultaneous();
    test_fairness();
    test_write_then_read();
    test_reset_mid();
    test_out_of_range();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer for the single-port 128-word data memory.
- Requester 0 (c_*): pipeline load/store stage.
- Requester 1 (d_*): debug/loader port for preloading and inspecting data memory at runtime.
- Serialises accesses, drives the memory's write enable, address and write data, and registers combinational read data into a per-requester response.

Parameters:
- DATA_W, 32, data word width.
- ADDR_W, 32, requester/memory address width (word index, matching the memory's indexing).
- DEPTH, 128, number of implemented memory words (used by the optional bounds check).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- c_req  in  1  core request; held with fields until c_gnt.
- c_we  in  1  core write (1) / read (0).
- c_addr  in  ADDR_W  core word address.
- c_wdata  in  DATA_W  core write data.
- c_gnt  out  1  one-cycle pulse: core request accepted, memory being accessed this cycle.
- c_ack  out  1  one-cycle pulse: core access complete; c_rdata valid if read.
- c_rdata  out  DATA_W  registered read data for core.
- d_req, d_we, d_addr, d_wdata, d_gnt, d_ack, d_rdata: same as c_* for debug port.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory combinational read data.
- busy  out  1  high in BUSY or RESP.

Behaviour:
- Reset (rst high at clk edge): state=IDLE; last_winner=1 (core wins first tie); all gnt/ack/mem_we=0; mem_addr, mem_wdata, c_rdata, d_rdata=0. Reset overrides any in-flight access; mem_we is gated by rst combinationally, so no write lands in the reset cycle.
- FSM states:
  - IDLE: if any req, arbitrate, latch winner id/we/addr/wdata into request register, go to BUSY. Else stay.
  - BUSY (exactly 1 cycle):
    - Drive mem_addr/mem_wdata from request register.
    - mem_we = latched we.
    - Pulse winner's gnt.
    - Capture mem_rdata into winner's rdata register (reads only; writes leave rdata unchanged).
    - last_winner <= winner.
    - Go to RESP.
  - RESP: pulse winner's ack. If any req this cycle, arbitrate and latch as in IDLE, then go to BUSY; else go to IDLE.
- Arbitration:
  - Single requester: it wins.
  - Both requesting: the one not equal to last_winner wins (round robin).
  - A requester whose req is still high in RESP, after its ack, is treated as a new request.
- Latency: req first sampled at edge N -> gnt and memory access in cycle N+1 -> ack and rdata valid in cycle N+2. Sustained throughput is one access per 2 cycles.
- Requesters must not change fields while req is high and gnt has not pulsed. Dropping req before gnt is illegal and yields undefined results.
- Outside BUSY: mem_we=0; mem_addr/mem_wdata hold last value.
- rdata registers hold until the next read by the same requester.

Optional Feature:
- Macro: DMEM_BOUNDS_CHECK_EN.
- Defined:
  - Request with addr >= DEPTH is still granted and acked.
  - mem_we is suppressed; returned rdata is 0.
  - Sticky output err (1 bit) is set, and cleared only by rst; err port exists only when defined.
- Undefined: no check, no err port; out-of-range addresses are passed through unchanged.

Decomposition:
- Shared package dmem_pkg:
  - state enum {IDLE, BUSY, RESP}.
  - requester id constants REQ_CORE=0, REQ_DBG=1.
  - DATA_W/ADDR_W/DEPTH defaults.
- Sub-module rr_arb2: combinational 2-way round-robin pick from req[1:0] and last_winner; outputs winner id and valid.

Test Plan:
- Core-only read, mem[5]=32'hDEADBEEF: c_req with addr=5 at edge N -> c_gnt in cycle N+1 with mem_addr=5 and mem_we=0 -> c_ack in N+2 with c_rdata=32'hDEADBEEF; d_* outputs stay 0.
- Simultaneous requests after reset: core read addr 3 and debug write addr 7 = 32'h12345678 -> core is served first (gnt N+1, ack N+2) -> debug gnt in N+3 with mem_we=1, mem_addr=7 -> debug ack in N+4.
- Fairness: both reqs held continuously for 8 accesses -> gnt alternates C,D,C,D,... with exactly one gnt per 2 cycles.
- Write-then-read: debug writes 32'hA5A5A5A5 to addr 10, then core reads addr 10 -> c_rdata=32'hA5A5A5A5.
- Reset mid-access: assert rst during a BUSY write cycle -> mem_we=0 that cycle, memory unchanged, next cycle state IDLE with all outputs 0.
- With DMEM_BOUNDS_CHECK_EN: core write to addr 200 -> gnt and ack occur, mem_we stays 0, err=1 and remains 1 until rst.
